// File: rtl/voq_grant_consumer.sv
// VOQ grant consumer: per-(input, output, priority) occupancy counters, request bitmap,
// and per-input transfer FSMs that take scheduler grants and hold the path for one cell time.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | input not transferring; may accept a valid grant
// ST_XFER | input sending a cell; down-counter counts remaining clocks
module voq_grant_consumer #(
    parameter int N           = 12,
    parameter int P           = 8,
    parameter int LOGN        = 4,
    parameter int LOGP        = 3,
    parameter int CNT_W       = 4,
    parameter int CELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_arr_valid,
    input  logic [LOGN-1:0]       i_arr_input,
    input  logic [LOGN-1:0]       i_arr_output,
    input  logic [LOGP-1:0]       i_arr_pri,
    input  logic [N*N-1:0]        i_acc_grant,
    input  logic [N*P-1:0]        i_acc_priority,
    output logic [N*N*P-1:0]      o_priority,
    output logic [N-1:0]          o_input_idle,
    output logic [N-1:0]          o_output_idle,
    output logic [N-1:0]          o_xfer_valid,
    output logic [N*LOGN-1:0]     o_xfer_output,
    output logic [N*LOGP-1:0]     o_xfer_pri,
    output logic                  o_drop,
    output logic                  o_grant_err
);

    localparam int NV   = N * N * P;
    localparam int DC_W = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    function automatic int voq_idx(input int j, input int i, input int k);
        return (j * N + i) * P + k;
    endfunction

    logic [CNT_W-1:0] cnt_q [NV];
    logic [CNT_W-1:0] cnt_d [NV];
    logic [NV-1:0]    prio_q, prio_d;
    logic             drop_q, drop_d;
    logic             gerr_q, gerr_d;

    state_t           state_q [N];
    state_t           state_d [N];
    logic [DC_W-1:0]  dcnt_q  [N];
    logic [DC_W-1:0]  dcnt_d  [N];
    logic [LOGN-1:0]  xout_q  [N];
    logic [LOGN-1:0]  xout_d  [N];
    logic [LOGP-1:0]  xpri_q  [N];
    logic [LOGP-1:0]  xpri_d  [N];

    logic [N-1:0]     g_row   [N];
    logic [P-1:0]     g_pf    [N];
    logic [LOGN-1:0]  g_out   [N];
    logic [LOGP-1:0]  g_pri   [N];
    logic [N-1:0]     req;
    logic [N-1:0]     in_free;
    logic [N-1:0]     out_busy;
    logic [N-1:0]     pre_ok;
    logic [N-1:0]     accept;
    logic [NV-1:0]    dec_mask;
    logic [NV-1:0]    inc_mask;
    logic             arr_in_range;
    logic             arr_sat;
    int               arr_idx;

    always_comb begin : grant_decode
        for (int j = 0; j < N; j++) begin
            g_row[j] = i_acc_grant[j*N +: N];
            g_pf[j]  = i_acc_priority[j*P +: P];
            req[j]   = |g_row[j];
            g_out[j] = '0;
            g_pri[j] = '0;
            for (int i = 0; i < N; i++)
                if (g_row[j][i]) g_out[j] = LOGN'(i);
            for (int k = 0; k < P; k++)
                if (g_pf[j][k]) g_pri[j] = LOGP'(k);
        end
    end

    // An input in its last transfer clock is already free, so back-to-back cells need no gap.
    always_comb begin : resource_state
        in_free  = '0;
        out_busy = '0;
        for (int j = 0; j < N; j++) begin
            in_free[j] = (state_q[j] == ST_IDLE) || (dcnt_q[j] == '0);
            for (int i = 0; i < N; i++)
                if (state_q[j] == ST_XFER && dcnt_q[j] != '0 && xout_q[j] == LOGN'(i))
                    out_busy[i] = 1'b1;
        end
    end

    always_comb begin : grant_check
        pre_ok = '0;
        for (int j = 0; j < N; j++)
            pre_ok[j] = $onehot(g_row[j]) && $onehot(g_pf[j])
                     && (cnt_q[voq_idx(j, int'(g_out[j]), int'(g_pri[j]))] != '0)
                     && in_free[j] && ((g_row[j] & out_busy) == '0);
    end

    always_comb begin : grant_accept
        accept = pre_ok;
        for (int j = 0; j < N; j++)
            for (int j2 = 0; j2 < N; j2++)
                if (j2 != j && pre_ok[j2] && g_out[j2] == g_out[j])
                    accept[j] = 1'b0;
        gerr_d = |(req & ~accept);
    end

    always_comb begin : voq_masks
        dec_mask     = '0;
        inc_mask     = '0;
        arr_in_range = (int'(i_arr_input) < N) && (int'(i_arr_output) < N)
                    && (int'(i_arr_pri) < P);
        arr_idx      = voq_idx(int'(i_arr_input), int'(i_arr_output), int'(i_arr_pri));
        for (int j = 0; j < N; j++)
            if (accept[j])
                dec_mask[voq_idx(j, int'(g_out[j]), int'(g_pri[j]))] = 1'b1;
        for (int v = 0; v < NV; v++)
            inc_mask[v] = i_arr_valid && arr_in_range && (arr_idx == v);
    end

    // Arrival and departure on one VOQ cancel, so a full counter still takes the arrival.
    always_comb begin : voq_next
        arr_sat = 1'b0;
        for (int v = 0; v < NV; v++) begin
            cnt_d[v] = cnt_q[v];
            if (inc_mask[v] && !dec_mask[v]) begin
                if (cnt_q[v] == {CNT_W{1'b1}}) arr_sat = 1'b1;
                else                           cnt_d[v] = cnt_q[v] + CNT_W'(1);
            end else if (dec_mask[v] && !inc_mask[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_W'(1);
            end
        end
        drop_d = i_arr_valid && (!arr_in_range || arr_sat);
        prio_d = '0;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < P; k++)
                for (int i = 0; i < N; i++)
                    prio_d[j*N*P + k*N + i] = (cnt_d[voq_idx(j, i, k)] != '0);
    end

    always_ff @(posedge clk) begin : voq_reg
        if (reset) begin
            for (int v = 0; v < NV; v++) cnt_q[v] <= '0;
            prio_q <= '0;
            drop_q <= 1'b0;
            gerr_q <= 1'b0;
        end else begin
            for (int v = 0; v < NV; v++) cnt_q[v] <= cnt_d[v];
            prio_q <= prio_d;
            drop_q <= drop_d;
            gerr_q <= gerr_d;
        end
    end

    always_ff @(posedge clk) begin : fsm_state_reg
        if (reset) begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= ST_IDLE;
                dcnt_q[j]  <= '0;
                xout_q[j]  <= '0;
                xpri_q[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                state_q[j] <= state_d[j];
                dcnt_q[j]  <= dcnt_d[j];
                xout_q[j]  <= xout_d[j];
                xpri_q[j]  <= xpri_d[j];
            end
        end
    end

    always_comb begin : fsm_next
        for (int j = 0; j < N; j++) begin
            state_d[j] = state_q[j];
            dcnt_d[j]  = dcnt_q[j];
            xout_d[j]  = xout_q[j];
            xpri_d[j]  = xpri_q[j];
            if (accept[j]) begin
                state_d[j] = ST_XFER;
                dcnt_d[j]  = DC_W'(CELL_CYCLES - 1);
                xout_d[j]  = g_out[j];
                xpri_d[j]  = g_pri[j];
            end else begin
                case (state_q[j])
                    ST_XFER: begin
                        if (dcnt_q[j] == '0) begin
                            state_d[j] = ST_IDLE;
                            xout_d[j]  = '0;
                            xpri_d[j]  = '0;
                        end else begin
                            dcnt_d[j] = dcnt_q[j] - DC_W'(1);
                        end
                    end
                    default: state_d[j] = ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin : fsm_out
        o_xfer_valid  = '0;
        o_xfer_output = '0;
        o_xfer_pri    = '0;
        o_output_idle = '1;
        for (int j = 0; j < N; j++) begin
            if (state_q[j] == ST_XFER) begin
                o_xfer_valid[j]              = 1'b1;
                o_xfer_output[j*LOGN +: LOGN] = xout_q[j];
                o_xfer_pri[j*LOGP +: LOGP]    = xpri_q[j];
                for (int i = 0; i < N; i++)
                    if (xout_q[j] == LOGN'(i)) o_output_idle[i] = 1'b0;
            end
        end
        o_input_idle = ~o_xfer_valid;
    end

    assign o_priority  = prio_q;
    assign o_drop      = drop_q;
    assign o_grant_err = gerr_q;

endmodule
